// File: rtl/alu_ctl_pkg.sv
// Shared types and field widths for the ALU request arbiter and its arbitration helper.
package alu_ctl_pkg;

  localparam int OP_W   = 6;
  localparam int FN_W   = 4;
  localparam int SEL_W  = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked_req;
  logic [ID_W-1:0] lo_masked;
  logic [ID_W-1:0] lo_all;
  logic            hit_masked;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked_req = req & mask;

    // Scan downward so the last hit is the lowest set index.
    lo_masked  = '0;
    lo_all     = '0;
    hit_masked = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        lo_masked  = ID_W'(i);
        hit_masked = 1'b1;
      end
      if (req[i]) begin
        lo_all = ID_W'(i);
      end
    end

    gnt_id = hit_masked ? lo_masked : lo_all;
    any    = |req;
    gnt    = '0;
    if (any) begin
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, fixed-latency wait,
// then a tagged response held until accepted.
module alu_req_arbiter
  import alu_ctl_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  ALU_LAT = 1,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_op,
  input  logic [NREQ*FN_W-1:0]   req_fn,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  output logic [OP_W-1:0]        alu_op,
  output logic [FN_W-1:0]        alu_fn,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_carry,
  input  logic                   alu_over,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_over,
  output logic                   busy,
  output state_t                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. req_ready is offered only in IDLE to the single arbitration winner;
  // rsp_valid stays high with rsp_* frozen until rsp_ready is seen.

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [FN_W-1:0]   alu_fn_q, alu_fn_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_over_q, rsp_over_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      w_q         <= '0;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_fn_q    <= '0;
      alu_sel_q   <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_over_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_fn_q    <= alu_fn_d;
      alu_sel_q   <= alu_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_over_q  <= rsp_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_fn_d    = alu_fn_q;
    alu_sel_d   = alu_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_over_d  = rsp_over_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = WAIT;
          w_d       = arb_id;
          cnt_d     = CNT_W'(ALU_LAT - 1);
          alu_op_d  = req_op[int'(arb_id)*OP_W +: OP_W];
          alu_fn_d  = req_fn[int'(arb_id)*FN_W +: FN_W];
          alu_sel_d = req_sel[int'(arb_id)*SEL_W +: SEL_W];
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_over_d  = alu_over;
          rsp_id_d    = w_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (w_q == ID_W'(NREQ - 1)) ? '0 : w_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) begin
      req_ready = arb_gnt;
    end
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
  end

  assign alu_op    = alu_op_q;
  assign alu_fn    = alu_fn_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_over  = rsp_over_q;
  assign dbg_state = state_q;

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Controller that shares the single 32-bit `MaingerALU` instance between `NREQ` requesters. Requesters present an ALU command (6-bit opcode, 4-bit function, four packed 2-bit selectors) with valid/ready handshake. The block grants one requester at a time in round-robin order and drives the ALU inputs from registers. It waits a fixed ALU latency, captures the result and the carry/overflow flags, then returns them tagged with the requester index over a valid/ready response channel.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `ALU_LAT`, 1: cycles from ALU inputs being driven to result sampling, ≥1
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester command valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_op`  in  NREQ*6  opcode per requester (ALU `r1`), requester i at [6i+5:6i]
- `req_fn`  in  NREQ*4  function field per requester (ALU `r6`)
- `req_sel`  in  NREQ*8  packed selectors {r2,r3,r4,r5} per requester, r2 in MSBs
- `alu_op`, `alu_fn`, `alu_sel`  out  6/4/8  registered drive to ALU `r1`/`r6`/{`r2`..`r5`}
- `alu_out`  in  32  ALU result
- `alu_carry`, `alu_over`  in  1  ALU flags
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  $clog2(NREQ)  index of served requester
- `rsp_data`  out  32  captured result
- `rsp_carry`, `rsp_over`  out  1  captured flags
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, the round-robin pick, searching upward from `rr_ptr` with wrap, gets `req_ready[w]`=1. This is combinational from `req_valid`, state and `rr_ptr`.
  - On the edge, latch `w` and the command into `alu_*` regs, load `cnt`=ALU_LAT-1, and go to WAIT.
  - With no request, stay in IDLE with `req_ready`=0.
- WAIT:
  - `req_ready`=0 and the `alu_*` regs are held.
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, capture `alu_out`/`alu_carry`/`alu_over` into the `rsp_*` regs, set `rsp_id`=`w`, and go to RESP.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` are stable until accepted.
  - On `rsp_valid`&`rsp_ready`, set `rr_ptr`=(w+1) mod NREQ and go to IDLE.
- `alu_*` keep the last issued command after the op completes; they are not cleared.
- A requester dropping `req_valid` without handshake is legal and is simply not granted.
- Widths: the selector packing is fixed. Result and flags pass through unmodified; no arithmetic in this block.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `cnt`=0.
  - `alu_op`=0, `alu_fn`=0, `alu_sel`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_carry`=0, `rsp_over`=0.
  - `busy`=0; `req_ready`=0 during reset.
- Latency: accept at edge T0 gives `rsp_valid` high from cycle T0+ALU_LAT+1.
- Throughput: with `rsp_ready` held high, one op per ALU_LAT+2 cycles. Next accept is possible in the cycle after the response handshake.
- Simultaneous requests: exactly one grant. Losers keep `req_valid` and are served in later rounds in rotating order; no starvation.
- `rsp_ready` low in RESP: hold indefinitely and issue no new grant.
- `rst` asserted mid-op: immediate return to IDLE with reset values. The in-flight op is dropped with no response.

## Structure
- Package `alu_ctl_pkg`:
  - state enum (IDLE, WAIT, RESP)
  - `OP_W`=6, `FN_W`=4, `SEL_W`=8, `DATA_W`=32
- Sub-module `rr_arbiter`:
  - purely combinational
  - inputs: `req[NREQ]`, `ptr`
  - outputs: one-hot `gnt`, index `gnt_id`, `any`
  - masked-priority implementation

## Test plan
- Single request: req 2 valid with op=6'b000001, fn=4'b0001, sel=8'b00101000; ALU model returns 0x0000_00A5, carry=1.
  - Required: `req_ready[2]` for 1 cycle; `alu_sel`=8'b00101000; `rsp_valid` 2 cycles after accept with id=2, data=0x0000_00A5, carry=1, over=0.
- All four requesting continuously from reset: grants in order 0,1,2,3,0, each `rsp_id` matching.
- Backpressure: `rsp_ready` low for 5 cycles in RESP.
  - Required: `rsp_*` stable, `req_ready` all 0, and the grant after release goes to the next index.
- `ALU_LAT`=3: `rsp_valid` 4 cycles after accept; ALU output changing in intermediate WAIT cycles is not captured.
- Reset mid-WAIT:
  - Required: all outputs return to reset values at once and no response is emitted.
  - After release, req 0 is granted first.
- Requester 1 deasserts valid before grant while req 3 is valid: req 3 is granted and `rr_ptr` becomes 0 after its response.
